mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single data-memory port of the pipelined CPU between the memory stage and an external word-stream loader (host input path). The CPU has priority, the loader steals idle slots, and a starvation counter forces bounded loader bursts while the memory stage is stalled. The block sits between the execute/memory pipeline register outputs and the data memory. It also owns the loader's auto-incrementing, wrapping write address.

## Interface
Parameters:
- EXT_BASE, 32'h0001_0000, byte address of the first loader word.
- EXT_WORDS, 64, number of words in the loader window (≥2). Addresses wrap after this many words.
- STARVE_LIMIT, 4, number of consecutive blocked loader cycles before the loader is forced to own the port (≥1).
- BURST_LEN, 4, maximum loader beats per forced ownership (≥1).
- WORD_SEL, 2'b00, byte-select code driven for loader writes (full word).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- cpu_req, in, 1, memory stage needs the port this cycle (load or store).
- cpu_we, in, 1, memory-stage store.
- cpu_addr, in, 32, memory-stage address.
- cpu_wdata, in, 32, memory-stage store data.
- cpu_byte_sel, in, 2, memory-stage byte format.
- cpu_stall, out, 1, memory stage must hold; upstream stages freeze.
- cpu_rdata, out, 32, read data returned to the memory stage.
- ext_valid, in, 1, loader word available.
- ext_data, in, 32, loader word.
- ext_ready, out, 1, loader beat accepted this cycle. A beat occurs when ext_valid & ext_ready.
- ext_clear, in, 1, synchronous restart of the loader address to EXT_BASE.
- ext_wrap, out, 1, one-cycle pulse after the last window word is written.
- mem_addr, out, 32, port address.
- mem_we, out, 1, port write enable.
- mem_wdata, out, 32, port write data.
- mem_byte_sel, out, 2, port byte format.
- mem_rdata, in, 32, port read data (combinational read).

## Operation
State register `owner` takes values OWN_CPU or OWN_EXT.

- **OWN_CPU, cpu_req=1:**
  - Port is driven by the cpu_* inputs. cpu_stall=0. ext_ready=0.
  - If ext_valid=1, wait_cnt increments. When wait_cnt reaches STARVE_LIMIT, the next state is OWN_EXT and wait_cnt clears.
- **OWN_CPU, cpu_req=0:**
  - If ext_valid=1, the port is driven by the loader: mem_we=1, mem_addr=ext_addr, mem_wdata=ext_data, mem_byte_sel=WORD_SEL. ext_ready=1.
  - If ext_valid=0, mem_we=0 and wait_cnt clears.
- **OWN_EXT:**
  - Port is driven by the loader. ext_ready=1. mem_we=ext_valid. cpu_stall=cpu_req.
  - beat_cnt counts beats.
  - Return to OWN_CPU when a beat makes beat_cnt equal BURST_LEN, or when ext_valid=0. beat_cnt clears on exit.
- **Read path:** cpu_rdata=mem_rdata at all times. It is only meaningful when cpu_stall=0.
- **Loader address:**
  - Each beat advances ext_addr by 4.
  - After the beat at EXT_BASE+4·(EXT_WORDS−1), ext_addr becomes EXT_BASE and ext_wrap pulses the next cycle.
  - ext_clear sets ext_addr=EXT_BASE. If ext_clear coincides with a beat, the beat writes the current address and ext_addr still becomes EXT_BASE, with no ext_wrap.
- **Reset values:**
  - owner=OWN_CPU, wait_cnt=0, beat_cnt=0, ext_addr=EXT_BASE, ext_wrap=0, statistics=0.
  - Outputs then follow the OWN_CPU rules combinationally.
  - Reset during an OWN_EXT burst abandons the burst. Beats already accepted remain written.

## Timing
- The port mux, cpu_stall and ext_ready are combinational from the current state and inputs.
- cpu_stall has zero cycles of latency from owner=OWN_EXT.
- State, counters and ext_addr update on the rising edge.
- The cycle in which wait_cnt reaches STARVE_LIMIT still serves the CPU. OWN_EXT begins on the next cycle.
- Worst-case CPU stall is BURST_LEN consecutive cycles. This is followed by at least STARVE_LIMIT CPU-served cycles before the next forced burst.
- Idle-slot loader writes cost the CPU zero cycles.

## Configuration
- MEM_ARB_STATS_EN defined:
  - Adds outputs stall_cycles[31:0], counting cycles with cpu_stall=1, and ext_beats[31:0], counting every beat.
  - Both are saturating, reset to 0, and updated at the clock edge.
- MEM_ARB_STATS_EN undefined: both ports exist but are tied to 0, and no counter logic is present.

## Test plan
- **Idle-slot write:** reset, then cpu_req=0 and ext_valid=1 for 3 cycles with data 0xA,0xB,0xC. Required: writes go to EXT_BASE, +4 and +8, ext_ready=1 on all three cycles, cpu_stall never asserted.
- **Starvation:** cpu_req=1 and ext_valid=1 continuously, defaults. Required: 4 CPU-served cycles, then cpu_stall=1 for exactly 4 cycles carrying 4 loader writes, then cpu_stall=0; the pattern repeats.
- **Early burst exit:** enter OWN_EXT, then drop ext_valid after 2 beats. Required: owner returns to OWN_CPU on the next edge, beat_cnt=0, stall lasts 3 cycles.
- **Wrap:** EXT_WORDS=4, 4 idle-slot beats. Required: the 4th write goes to EXT_BASE+12, ext_wrap=1 for one cycle, and the 5th write goes to EXT_BASE.
- **Clear with beat:** ext_clear=1 in the same cycle as a beat at EXT_BASE+8. Required: the write lands at +8, the next beat goes to EXT_BASE, and there is no ext_wrap.
- **Async reset mid-burst:** assert rst between edges during OWN_EXT. Required: cpu_stall=0 immediately, ext_addr=EXT_BASE, and with MEM_ARB_STATS_EN both counters read 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Data-memory port arbiter: the CPU memory stage has priority, the word-stream loader fills idle slots
// and gets forced bursts when starved. Optional statistics counters are enabled by MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter logic [31:0] EXT_BASE     = 32'h0001_0000,
  parameter int          EXT_WORDS    = 64,
  parameter int          STARVE_LIMIT = 4,
  parameter int          BURST_LEN    = 4,
  parameter logic [1:0]  WORD_SEL     = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_byte_sel,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        ext_valid,
  input  logic [31:0] ext_data,
  output logic        ext_ready,
  input  logic        ext_clear,
  output logic        ext_wrap,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_byte_sel,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stall_cycles,
  output logic [31:0] ext_beats
);

  typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

  localparam int                WAIT_W    = $clog2(STARVE_LIMIT + 1);
  localparam int                BEAT_W    = $clog2(BURST_LEN + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [31:0]       EXT_LAST  = EXT_BASE + 32'(4 * (EXT_WORDS - 1));

  owner_t            owner, owner_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt;
  logic [31:0]       ext_addr;
  logic              loader_port;
  logic              beat;

  assign cpu_rdata = mem_rdata;
  assign beat      = ext_valid & ext_ready;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    owner_nxt    = owner;
    wait_nxt     = wait_cnt;
    beat_nxt     = beat_cnt;
    cpu_stall    = 1'b0;
    ext_ready    = 1'b0;
    loader_port  = 1'b0;
    mem_addr     = cpu_addr;
    mem_we       = 1'b0;
    mem_wdata    = cpu_wdata;
    mem_byte_sel = cpu_byte_sel;

    unique case (owner)
      OWN_CPU: begin
        wait_nxt = '0;
        if (cpu_req) begin
          mem_we = cpu_we;
          if (ext_valid) begin
            // The cycle that hits the limit still serves the CPU; the burst starts next cycle.
            if (wait_cnt == WAIT_LAST) owner_nxt = OWN_EXT;
            else                       wait_nxt  = wait_cnt + 1'b1;
          end
        end else if (ext_valid) begin
          loader_port = 1'b1;
          ext_ready   = 1'b1;
        end
      end
      OWN_EXT: begin
        loader_port = 1'b1;
        ext_ready   = 1'b1;
        cpu_stall   = cpu_req;
        if (!ext_valid || beat_cnt == BEAT_LAST) begin
          owner_nxt = OWN_CPU;
          beat_nxt  = '0;
        end else begin
          beat_nxt  = beat_cnt + 1'b1;
        end
      end
      default: owner_nxt = OWN_CPU;
    endcase

    if (loader_port) begin
      mem_addr     = ext_addr;
      mem_we       = ext_valid;
      mem_wdata    = ext_data;
      mem_byte_sel = WORD_SEL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= OWN_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
      ext_addr <= EXT_BASE;
      ext_wrap <= 1'b0;
    end else begin
      owner    <= owner_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
      ext_wrap <= beat && !ext_clear && ext_addr == EXT_LAST;
      if (ext_clear || (beat && ext_addr == EXT_LAST)) ext_addr <= EXT_BASE;
      else if (beat)                                   ext_addr <= ext_addr + 32'd4;
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      ext_beats    <= '0;
    end else begin
      if (cpu_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (beat && ext_beats != '1)         ext_beats    <= ext_beats + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign ext_beats    = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (EXT_WORDS=4 so the wrap is reachable quickly).
module tb_mem_port_arbiter;

  localparam logic [31:0] B  = 32'h0001_0000;
  localparam logic [31:0] CA = 32'h0000_0100;
  localparam logic [31:0] CW = 32'h5555_AAAA;
  localparam logic [1:0]  CS = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_valid, ext_clear;
  logic [31:0] cpu_addr, cpu_wdata, ext_data, mem_rdata;
  logic [1:0]  cpu_byte_sel;
  logic        cpu_stall, ext_ready, ext_wrap, mem_we;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, stall_cycles, ext_beats;
  logic [1:0]  mem_byte_sel;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.EXT_BASE(B), .EXT_WORDS(4), .STARVE_LIMIT(4), .BURST_LEN(4), .WORD_SEL(2'b00)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byte_sel(cpu_byte_sel), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ext_ready),
    .ext_clear(ext_clear), .ext_wrap(ext_wrap),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_byte_sel(mem_byte_sel), .mem_rdata(mem_rdata),
    .stall_cycles(stall_cycles), .ext_beats(ext_beats)
  );

  typedef struct {
    logic        req, valid, clr;
    logic [31:0] data;
    logic        exp_stall, exp_ready, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic vec_t v(input logic req, valid, clr, input logic [31:0] data,
                             input logic stall, ready, we, input logic [31:0] addr, wdata,
                             input logic wrap);
    vec_t r;
    r.req = req; r.valid = valid; r.clr = clr; r.data = data;
    r.exp_stall = stall; r.exp_ready = ready; r.exp_we = we;
    r.exp_addr = addr; r.exp_wdata = wdata; r.exp_wrap = wrap;
    return r;
  endfunction

  task automatic cpu_served(input logic [31:0] data);
    vecs.push_back(v(1, 1, 0, data, 0, 0, 1, CA, CW, 0));
  endtask

  initial begin
    int exp_stalls = 0;
    int exp_beats  = 0;
    bit saw_burst  = 0;

    // Idle-slot writes, then wrap with the 5th write back at EXT_BASE.
    vecs.push_back(v(0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  0));
    vecs.push_back(v(0, 1, 0, 32'hA,  0, 1, 1, B,      32'hA,  0));
    vecs.push_back(v(0, 1, 0, 32'hB,  0, 1, 1, B + 4,  32'hB,  0));
    vecs.push_back(v(0, 1, 0, 32'hC,  0, 1, 1, B + 8,  32'hC,  0));
    vecs.push_back(v(0, 1, 0, 32'hD,  0, 1, 1, B + 12, 32'hD,  0));
    vecs.push_back(v(0, 0, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,  1));
    vecs.push_back(v(0, 1, 0, 32'hE,  0, 1, 1, B,      32'hE,  0));
    vecs.push_back(v(0, 1, 0, 32'hF,  0, 1, 1, B + 4,  32'hF,  0));
    // Clear coinciding with the beat at +8: write at +8, next beat at base, no wrap.
    vecs.push_back(v(0, 1, 1, 32'h11, 0, 1, 1, B + 8,  32'h11, 0));
    vecs.push_back(v(0, 1, 0, 32'h12, 0, 1, 1, B,      32'h12, 0));
    // Starvation: 4 CPU cycles, 4 stalled loader beats, then 4 CPU cycles again.
    for (int k = 0; k < 4; k++) cpu_served(32'h20 + k);
    vecs.push_back(v(1, 1, 0, 32'h30, 1, 1, 1, B + 4,  32'h30, 0));
    vecs.push_back(v(1, 1, 0, 32'h31, 1, 1, 1, B + 8,  32'h31, 0));
    vecs.push_back(v(1, 1, 0, 32'h32, 1, 1, 1, B + 12, 32'h32, 0));
    vecs.push_back(v(1, 1, 0, 32'h33, 1, 1, 1, B,      32'h33, 1));
    for (int k = 0; k < 4; k++) cpu_served(32'h34 + k);
    // Early exit: 2 beats, then ext_valid drops; stall lasts 3 cycles.
    vecs.push_back(v(1, 1, 0, 32'h40, 1, 1, 1, B + 4,  32'h40, 0));
    vecs.push_back(v(1, 1, 0, 32'h41, 1, 1, 1, B + 8,  32'h41, 0));
    vecs.push_back(v(1, 0, 0, 32'h0,  1, 1, 0, 32'h0,  32'h0,  0));
    vecs.push_back(v(1, 0, 0, 32'h0,  0, 0, 1, CA,     CW,     0));
    // Next forced burst is a full 4 beats, so the beat count restarted at 0.
    for (int k = 0; k < 4; k++) cpu_served(32'h44 + k);
    vecs.push_back(v(1, 1, 0, 32'h50, 1, 1, 1, B + 12, 32'h50, 0));
    vecs.push_back(v(1, 1, 0, 32'h51, 1, 1, 1, B,      32'h51, 1));
    vecs.push_back(v(1, 1, 0, 32'h52, 1, 1, 1, B + 4,  32'h52, 0));
    vecs.push_back(v(1, 1, 0, 32'h53, 1, 1, 1, B + 8,  32'h53, 0));
    cpu_served(32'h60);

    rst = 1'b1;
    cpu_req = 0; cpu_we = 1; cpu_addr = CA; cpu_wdata = CW; cpu_byte_sel = CS;
    ext_valid = 1; ext_clear = 0; ext_data = 32'h99; mem_rdata = 32'h0;
    #12;
    check("reset_stall", {31'b0, cpu_stall}, 32'd0);
    check("reset_ready", {31'b0, ext_ready}, 32'd1);
    check("reset_addr",  mem_addr, B);
    check("reset_wrap",  {31'b0, ext_wrap}, 32'd0);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    check("reset_ext_beats",    ext_beats,    32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cpu_req   = vecs[i].req;
      ext_valid = vecs[i].valid;
      ext_clear = vecs[i].clr;
      ext_data  = vecs[i].data;
      mem_rdata = 32'hC0DE_0000 + 32'(i);
      #1;
      check($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].exp_stall});
      check($sformatf("v%0d_ready", i), {31'b0, ext_ready}, {31'b0, vecs[i].exp_ready});
      check($sformatf("v%0d_we", i),    {31'b0, mem_we},    {31'b0, vecs[i].exp_we});
      check($sformatf("v%0d_wrap", i),  {31'b0, ext_wrap},  {31'b0, vecs[i].exp_wrap});
      check($sformatf("v%0d_rdata", i), cpu_rdata, 32'hC0DE_0000 + 32'(i));
      if (vecs[i].exp_we) begin
        check($sformatf("v%0d_addr", i),  mem_addr,  vecs[i].exp_addr);
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_sel", i), {30'b0, mem_byte_sel}, {30'b0, (vecs[i].exp_ready ? 2'b00 : CS)});
      end
      if (vecs[i].exp_stall) exp_stalls++;
      if (vecs[i].exp_ready && vecs[i].valid) exp_beats++;
      @(negedge clk);
    end

`ifdef MEM_ARB_STATS_EN
    check("stat_stall_cycles", stall_cycles, 32'(exp_stalls));
    check("stat_ext_beats",    ext_beats,    32'(exp_beats));
`else
    check("stat_stall_cycles_tied", stall_cycles, 32'd0);
    check("stat_ext_beats_tied",    ext_beats,    32'd0);
`endif

    // Async reset in the middle of a forced burst.
    cpu_req = 1; ext_valid = 1; ext_clear = 0; ext_data = 32'h70;
    for (int c = 0; c < 8 && !saw_burst; c++) begin
      @(negedge clk);
      #1;
      if (cpu_stall) saw_burst = 1;
    end
    check("burst_reached", {31'b0, saw_burst}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_burst_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_mid_burst_ready", {31'b0, ext_ready}, 32'd0);
    check("rst_mid_burst_addr",  mem_addr, CA);
    check("rst_mid_burst_stall_cycles", stall_cycles, 32'd0);
    check("rst_mid_burst_ext_beats",    ext_beats,    32'd0);
    cpu_req = 0;
    #1;
    check("rst_ext_addr", mem_addr, B);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_addr",  mem_addr, B);
    check("post_rst_wdata", mem_wdata, 32'h70);
    check("post_rst_wrap",  {31'b0, ext_wrap}, 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
